// File: rtl/cache_control_wb_if.sv
// Bundle of CPU-port, physical-memory-port and cache-datapath control signals
// between the cache controller (slave) and its environment (master).
interface cache_control_wb_if #(
  parameter int WAYS  = 2,
  parameter int CNT_W = 16
);
  logic             mem_read;
  logic             mem_write;
  logic [WAYS-1:0]  hit_vec;
  logic [WAYS-1:0]  valid_vec;
  logic [WAYS-1:0]  dirty_vec;
  logic [WAYS-2:0]  plru_out;
  logic             pmem_resp;

  logic             mem_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic [WAYS-1:0]  load_data;
  logic             data_from_pmem;
  logic [WAYS-1:0]  load_tag;
  logic [WAYS-1:0]  load_valid;
  logic [WAYS-1:0]  load_dirty;
  logic             dirty_in;
  logic             load_plru;
  logic [WAYS-2:0]  plru_in;
  logic             wb_addr_sel;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport slave (
    input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_out, pmem_resp,
    output mem_resp, pmem_read, pmem_write, load_data, data_from_pmem, load_tag,
           load_valid, load_dirty, dirty_in, load_plru, plru_in, wb_addr_sel,
           hit_count, miss_count
  );

  modport master (
    output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, plru_out, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, load_data, data_from_pmem, load_tag,
           load_valid, load_dirty, dirty_in, load_plru, plru_in, wb_addr_sel,
           hit_count, miss_count
  );
endinterface

// File: rtl/cache_control_wb.sv
// N-way write-back / write-allocate L1 cache controller with tree pseudo-LRU,
// invalid-way-first fill, victim write-back and saturating hit/miss counters.
//
// state      | meaning
// IDLE       | serve hits, classify misses and pick a victim
// WRITE_BACK | dirty victim line being written to physical memory
// ALLOCATE   | line fill from physical memory into the victim way
module cache_control_wb #(
  parameter int WAYS  = 2,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset,
  cache_control_wb_if.slave bus
);
  localparam int LW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, ALLOCATE} state_t;

  state_t          state, state_next;
  logic [LW-1:0]   victim, victim_next;
  logic            hit_inc, miss_inc;
  logic            req, is_write;
  logic [LW-1:0]   hit_way;

  function automatic logic [LW-1:0] lowest_idx(input logic [WAYS-1:0] v);
    logic [WAYS-1:0] tmp;
    lowest_idx = '0;
    for (int i = WAYS-1; i >= 0; i--) begin
      tmp = v >> i;
      if (tmp[0]) lowest_idx = LW'(i);
    end
  endfunction

  // Tree padded to 7 nodes so WAYS up to 8 share one indexing scheme.
  function automatic logic [LW-1:0] plru_victim(input logic [WAYS-2:0] t);
    logic [6:0] tree;
    logic [2:0] vx;
    logic       d;
    int         n;
    tree = '0;
    tree[WAYS-2:0] = t;
    vx = '0;
    n  = 0;
    for (int l = 0; l < LW; l++) begin
      d  = tree[n[2:0]];
      vx = (vx << 1) | {2'b00, d};
      n  = 2*n + (d ? 2 : 1);
    end
    plru_victim = LW'(vx);
  endfunction

  function automatic logic [WAYS-2:0] plru_update(input logic [WAYS-2:0] t,
                                                   input logic [LW-1:0]   w);
    logic [6:0] tree;
    logic [2:0] wx, tmp;
    logic       dir;
    int         n;
    tree = '0;
    tree[WAYS-2:0] = t;
    wx = 3'(w);
    n  = 0;
    for (int l = 0; l < LW; l++) begin
      tmp = wx >> (LW-1-l);
      dir = tmp[0];
      tree[n[2:0]] = ~dir;
      n = 2*n + (dir ? 2 : 1);
    end
    plru_update = tree[WAYS-2:0];
  endfunction

  assign req      = bus.mem_read | bus.mem_write;
  assign is_write = bus.mem_write & ~bus.mem_read;
  assign hit_way  = lowest_idx(bus.hit_vec);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      victim         <= '0;
      bus.hit_count  <= '0;
      bus.miss_count <= '0;
    end else begin
      state  <= state_next;
      victim <= victim_next;
      if (hit_inc && bus.hit_count != {CNT_W{1'b1}})
        bus.hit_count <= bus.hit_count + 1'b1;
      if (miss_inc && bus.miss_count != {CNT_W{1'b1}})
        bus.miss_count <= bus.miss_count + 1'b1;
    end
  end

  always_comb begin
    state_next         = state;
    victim_next        = victim;
    hit_inc            = 1'b0;
    miss_inc           = 1'b0;
    bus.mem_resp       = 1'b0;
    bus.pmem_read      = 1'b0;
    bus.pmem_write     = 1'b0;
    bus.load_data      = '0;
    bus.data_from_pmem = 1'b0;
    bus.load_tag       = '0;
    bus.load_valid     = '0;
    bus.load_dirty     = '0;
    bus.dirty_in       = 1'b0;
    bus.load_plru      = 1'b0;
    bus.plru_in        = '0;
    bus.wb_addr_sel    = 1'b0;
    // Strobes are combinational, so they must be forced low while reset is held.
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (|bus.hit_vec) begin
              bus.mem_resp  = 1'b1;
              bus.load_plru = 1'b1;
              bus.plru_in   = plru_update(bus.plru_out, hit_way);
              hit_inc       = 1'b1;
              if (is_write) begin
                bus.load_data  = WAYS'(1) << hit_way;
                bus.load_dirty = WAYS'(1) << hit_way;
                bus.dirty_in   = 1'b1;
              end
            end else begin
              miss_inc    = 1'b1;
              victim_next = (~&bus.valid_vec) ? lowest_idx(~bus.valid_vec)
                                              : plru_victim(bus.plru_out);
              state_next  = (bus.valid_vec[victim_next] & bus.dirty_vec[victim_next])
                            ? WRITE_BACK : ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          bus.pmem_write  = 1'b1;
          bus.wb_addr_sel = 1'b1;
          if (bus.pmem_resp) state_next = ALLOCATE;
        end
        ALLOCATE: begin
          bus.pmem_read      = 1'b1;
          bus.data_from_pmem = 1'b1;
          if (bus.pmem_resp) begin
            bus.load_data  = WAYS'(1) << victim;
            bus.load_tag   = WAYS'(1) << victim;
            bus.load_valid = WAYS'(1) << victim;
            bus.load_dirty = WAYS'(1) << victim;
            state_next     = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_control_wb.sv
// Directed bench for cache_control_wb: a 2-way/4-bit-counter instance and a
// 4-way/16-bit-counter instance sharing clock and reset.
module tb_cache_control_wb;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  cache_control_wb_if #(.WAYS(2), .CNT_W(4))  bus_a ();
  cache_control_wb_if #(.WAYS(4), .CNT_W(16)) bus_b ();

  cache_control_wb #(.WAYS(2), .CNT_W(4))  dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  cache_control_wb #(.WAYS(4), .CNT_W(16)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    string      name;
    logic       rd, wr;
    logic [3:0] hit, valid, dirty;
    logic [2:0] plru;
    logic       resp;
    logic [3:0] ldata, ldirty;
    logic       din, lplru;
    logic [2:0] pin;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.mem_read = 0; bus_a.mem_write = 0; bus_a.hit_vec = '0; bus_a.valid_vec = '0;
    bus_a.dirty_vec = '0; bus_a.plru_out = '0; bus_a.pmem_resp = 0;
    bus_b.mem_read = 0; bus_b.mem_write = 0; bus_b.hit_vec = '0; bus_b.valid_vec = '0;
    bus_b.dirty_vec = '0; bus_b.plru_out = '0; bus_b.pmem_resp = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"noreq",      0,0, 4'b0001,4'hF,4'h0,3'b000, 0,4'b0000,4'b0000,0,0,3'b000};
    vecs[1] = '{"rd_hit_w0",  1,0, 4'b0001,4'hF,4'h0,3'b000, 1,4'b0000,4'b0000,0,1,3'b011};
    vecs[2] = '{"wr_hit_w0",  0,1, 4'b0001,4'hF,4'h0,3'b000, 1,4'b0001,4'b0001,1,1,3'b011};
    vecs[3] = '{"rd_hit_w3",  1,0, 4'b1000,4'hF,4'h0,3'b111, 1,4'b0000,4'b0000,0,1,3'b010};
    vecs[4] = '{"wr_hit_w2",  0,1, 4'b0100,4'hF,4'h0,3'b111, 1,4'b0100,4'b0100,1,1,3'b110};
    vecs[5] = '{"rd_hit_w1",  1,0, 4'b0010,4'hF,4'h0,3'b000, 1,4'b0000,4'b0000,0,1,3'b001};
    vecs[6] = '{"rdwr_is_rd", 1,1, 4'b0010,4'hF,4'h0,3'b000, 1,4'b0000,4'b0000,0,1,3'b001};
    vecs[7] = '{"multi_hit",  0,1, 4'b1100,4'hF,4'h0,3'b000, 1,4'b0100,4'b0100,1,1,3'b100};
    vecs[8] = '{"noreq_hits", 0,0, 4'b1111,4'hF,4'h0,3'b111, 0,4'b0000,4'b0000,0,0,3'b000};

    idle_inputs();
    // Outputs held low during reset even with a hitting request present.
    #2;
    bus_b.mem_read = 1; bus_b.hit_vec = 4'b0001; bus_b.valid_vec = 4'hF;
    #2;
    chk("rst_mem_resp", 32'(bus_b.mem_resp), 32'd0);
    chk("rst_load_plru", 32'(bus_b.load_plru), 32'd0);
    chk("rst_hit_count", 32'(bus_b.hit_count), 32'd0);
    tick();
    reset = 0;
    idle_inputs();

    // Table: IDLE-state hit/no-request behaviour on the 4-way instance.
    for (int i = 0; i < 9; i++) begin
      tick();
      bus_b.mem_read = vecs[i].rd; bus_b.mem_write = vecs[i].wr;
      bus_b.hit_vec = vecs[i].hit; bus_b.valid_vec = vecs[i].valid;
      bus_b.dirty_vec = vecs[i].dirty; bus_b.plru_out = vecs[i].plru;
      #2;
      chk({vecs[i].name, "_resp"},   32'(bus_b.mem_resp),   32'(vecs[i].resp));
      chk({vecs[i].name, "_ldata"},  32'(bus_b.load_data),  32'(vecs[i].ldata));
      chk({vecs[i].name, "_ldirty"}, 32'(bus_b.load_dirty), 32'(vecs[i].ldirty));
      chk({vecs[i].name, "_din"},    32'(bus_b.dirty_in),   32'(vecs[i].din));
      chk({vecs[i].name, "_lplru"},  32'(bus_b.load_plru),  32'(vecs[i].lplru));
      chk({vecs[i].name, "_pin"},    32'(bus_b.plru_in),    32'(vecs[i].pin));
    end
    tick();
    idle_inputs();
    #2;
    chk("tbl_hit_count", 32'(bus_b.hit_count), 32'd7);
    chk("tbl_miss_count", 32'(bus_b.miss_count), 32'd0);

    // 2-way cold read miss, fill after 5 cycles, re-hit.
    tick();
    bus_a.mem_read = 1;
    #2;
    chk("a_miss_resp", 32'(bus_a.mem_resp), 32'd0);
    chk("a_miss_pread", 32'(bus_a.pmem_read), 32'd0);
    tick();
    #2;
    chk("a_alloc_pread", 32'(bus_a.pmem_read), 32'd1);
    chk("a_alloc_dfp", 32'(bus_a.data_from_pmem), 32'd1);
    chk("a_alloc_pwrite", 32'(bus_a.pmem_write), 32'd0);
    chk("a_alloc_ldata_idle", 32'(bus_a.load_data), 32'd0);
    repeat (4) tick();
    bus_a.pmem_resp = 1;
    #2;
    chk("a_fill_ldata", 32'(bus_a.load_data), 32'b01);
    chk("a_fill_ltag", 32'(bus_a.load_tag), 32'b01);
    chk("a_fill_lvalid", 32'(bus_a.load_valid), 32'b01);
    chk("a_fill_ldirty", 32'(bus_a.load_dirty), 32'b01);
    chk("a_fill_din", 32'(bus_a.dirty_in), 32'd0);
    chk("a_fill_lplru", 32'(bus_a.load_plru), 32'd0);
    chk("a_fill_resp", 32'(bus_a.mem_resp), 32'd0);
    tick();
    bus_a.pmem_resp = 0; bus_a.hit_vec = 2'b01; bus_a.valid_vec = 2'b01;
    #2;
    chk("a_rehit_resp", 32'(bus_a.mem_resp), 32'd1);
    chk("a_rehit_pin", 32'(bus_a.plru_in), 32'd1);
    chk("a_rehit_pread", 32'(bus_a.pmem_read), 32'd0);
    tick();
    idle_inputs();
    #2;
    chk("a_hit_count", 32'(bus_a.hit_count), 32'd1);
    chk("a_miss_count", 32'(bus_a.miss_count), 32'd1);

    // 4-way write miss, dirty PLRU victim way0: write-back, fill, write hit.
    tick();
    bus_b.mem_write = 1; bus_b.valid_vec = 4'hF; bus_b.dirty_vec = 4'b0001; bus_b.plru_out = 3'b000;
    #2;
    chk("b_wmiss_resp", 32'(bus_b.mem_resp), 32'd0);
    tick();
    #2;
    chk("b_wb_pwrite", 32'(bus_b.pmem_write), 32'd1);
    chk("b_wb_addrsel", 32'(bus_b.wb_addr_sel), 32'd1);
    chk("b_wb_pread", 32'(bus_b.pmem_read), 32'd0);
    tick();
    bus_b.pmem_resp = 1;
    #2;
    chk("b_wb_resp_pwrite", 32'(bus_b.pmem_write), 32'd1);
    tick();
    bus_b.pmem_resp = 0;
    #2;
    chk("b_alloc_pread", 32'(bus_b.pmem_read), 32'd1);
    chk("b_alloc_pwrite", 32'(bus_b.pmem_write), 32'd0);
    chk("b_alloc_addrsel", 32'(bus_b.wb_addr_sel), 32'd0);
    tick();
    bus_b.pmem_resp = 1;
    #2;
    chk("b_fill_ldata", 32'(bus_b.load_data), 32'b0001);
    chk("b_fill_ldirty", 32'(bus_b.load_dirty), 32'b0001);
    chk("b_fill_din", 32'(bus_b.dirty_in), 32'd0);
    tick();
    bus_b.pmem_resp = 0; bus_b.hit_vec = 4'b0001; bus_b.dirty_vec = 4'b0000;
    #2;
    chk("b_whit_resp", 32'(bus_b.mem_resp), 32'd1);
    chk("b_whit_ldata", 32'(bus_b.load_data), 32'b0001);
    chk("b_whit_ldirty", 32'(bus_b.load_dirty), 32'b0001);
    chk("b_whit_din", 32'(bus_b.dirty_in), 32'd1);
    chk("b_whit_dfp", 32'(bus_b.data_from_pmem), 32'd0);
    chk("b_whit_pin", 32'(bus_b.plru_in), 32'b011);
    tick();
    idle_inputs();

    // Clean PLRU victim way3; request dropped during the fill.
    tick();
    bus_b.mem_read = 1; bus_b.valid_vec = 4'hF; bus_b.plru_out = 3'b101;
    tick();
    bus_b.mem_read = 0;
    #2;
    chk("b_clean_pread", 32'(bus_b.pmem_read), 32'd1);
    chk("b_clean_pwrite", 32'(bus_b.pmem_write), 32'd0);
    tick();
    bus_b.pmem_resp = 1;
    #2;
    chk("b_clean_lvalid", 32'(bus_b.load_valid), 32'b1000);
    chk("b_drop_resp", 32'(bus_b.mem_resp), 32'd0);
    tick();
    bus_b.pmem_resp = 0;
    #2;
    chk("b_drop_idle_resp", 32'(bus_b.mem_resp), 32'd0);
    chk("b_drop_idle_pread", 32'(bus_b.pmem_read), 32'd0);

    // Invalid way preferred over PLRU; its stale dirty bit is ignored.
    tick();
    bus_b.mem_read = 1; bus_b.valid_vec = 4'b1011; bus_b.dirty_vec = 4'hF; bus_b.plru_out = 3'b000;
    tick();
    #2;
    chk("b_inv_pwrite", 32'(bus_b.pmem_write), 32'd0);
    chk("b_inv_pread", 32'(bus_b.pmem_read), 32'd1);
    bus_b.pmem_resp = 1;
    #2;
    chk("b_inv_lvalid", 32'(bus_b.load_valid), 32'b0100);
    tick();
    idle_inputs();
    #2;
    chk("b_miss_count", 32'(bus_b.miss_count), 32'd3);

    // Reset in WRITE_BACK aborts immediately.
    tick();
    bus_b.mem_write = 1; bus_b.valid_vec = 4'hF; bus_b.dirty_vec = 4'b0001;
    tick();
    #2;
    chk("b_pre_rst_pwrite", 32'(bus_b.pmem_write), 32'd1);
    reset = 1;
    #1;
    chk("b_rst_pwrite", 32'(bus_b.pmem_write), 32'd0);
    chk("b_rst_hit_count", 32'(bus_b.hit_count), 32'd0);
    chk("b_rst_miss_count", 32'(bus_b.miss_count), 32'd0);
    tick();
    reset = 0;
    idle_inputs();
    tick();
    #2;
    chk("b_post_rst_pwrite", 32'(bus_b.pmem_write), 32'd0);
    chk("b_post_rst_pread", 32'(bus_b.pmem_read), 32'd0);
    bus_b.mem_read = 1; bus_b.hit_vec = 4'b0010; bus_b.valid_vec = 4'hF;
    #1;
    chk("b_post_rst_hit", 32'(bus_b.mem_resp), 32'd1);
    tick();
    idle_inputs();

    // 20 read hits saturate the 4-bit hit counter.
    bus_a.mem_read = 1; bus_a.hit_vec = 2'b10; bus_a.valid_vec = 2'b11;
    repeat (20) tick();
    idle_inputs();
    #2;
    chk("a_sat_hit_count", 32'(bus_a.hit_count), 32'd15);
    chk("a_sat_miss_count", 32'(bus_a.miss_count), 32'd0);
    tick();
    #2;
    chk("a_idle_hold_count", 32'(bus_a.hit_count), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
